shift_right_iter: RTL and testbench
===================================

# shift_right_iter

Multi-cycle right shifter/rotator for the shift unit of the pipelined MIPS core, the right-direction counterpart of the cyclic left shifter. It accepts an operand, a shift amount and a mode over a valid/ready handshake. It resolves the shift one amount bit per cycle, as a sequential log-stage barrel. The result is returned on a second valid/ready handshake, so long-latency shifts can be decoupled from the execute stage.

## Interface
Parameters:
- `N`, 32, operand/result width; power of two, ≥ 2
- `K`, `$clog2(N)`, shift-amount width; derived, not overridden

Ports:
- `clk`  in  1  sole clock, rising edge
- `rst_n`  in  1  asynchronous, active-low reset
- `in_valid`  in  1  request present
- `in_ready`  out  1  block can accept a request
- `a`  in  N  operand
- `b`  in  K  shift amount
- `mode`  in  2  `shift_pkg::sr_mode_t`: SR_LOGIC=0, SR_ARITH=1, SR_ROT=2; value 3 reserved, treated as SR_LOGIC
- `r`  out  N  result
- `out_valid`  out  1  result present
- `out_ready`  in  1  consumer takes result

## Operation
- States: IDLE, SHIFT, DONE (`shift_pkg::sr_state_t`).
- `in_ready` = (state == IDLE); `out_valid` = (state == DONE).
- IDLE, on `in_valid & in_ready` at an edge:
  - register `a` into the working register, and `b` and `mode` into holding registers;
  - clear stage counter `idx` (K bits wide, or K+1 if needed to reach K);
  - go to SHIFT.
- SHIFT, each edge:
  - if `b_q[idx]`, shift the working register right by 2^idx, otherwise leave it unchanged;
  - fill bits: SR_LOGIC fills 0; SR_ARITH fills the original sign bit `a_q[N-1]`, captured at accept; SR_ROT fills the bits shifted out of the LSB end;
  - `idx++`; after stage K-1 go to DONE.
- DONE: `r` holds the result stable. On `out_valid & out_ready` go to IDLE.
- `r` always drives the working register. Its value is defined only while `out_valid` = 1.
- Inputs are sampled only at accept. Changes to `a`, `b` or `mode` afterwards have no effect. `in_valid` outside IDLE is ignored.
- Result equals `a >> b`, `$signed(a) >>> b`, or rotate-right(`a`, `b`) respectively.

## Timing
- Reset (`rst_n` = 0, asynchronous): state = IDLE, working reg = 0, `idx` = 0, `b_q` = 0, mode = SR_LOGIC. Outputs: `r` = 0, `out_valid` = 0, `in_ready` = 1.
- Fixed latency, independent of `b` (including `b` = 0, which yields `r` = `a`):
  - accept at edge T0;
  - stages at edges T1..TK;
  - `out_valid` = 1 after edge TK. For N = 32 that is 5 cycles after the accept edge.
- DONE persists while `out_ready` = 0, with `r` constant (backpressure).
- Handshake in DONE at edge Td: `in_ready` = 1 after Td. A new request is accepted no earlier than edge Td+1; there is no same-cycle turnaround.
- `out_ready` is ignored outside DONE.
- Throughput: one operation per K+2 cycles with no backpressure.
- Reset mid-operation (SHIFT or DONE) aborts immediately. No result is produced; the block is in IDLE when `rst_n` rises.

## Structure
- Package `shift_pkg` holds:
  - `sr_mode_t` enum (2-bit);
  - `sr_state_t` enum;
  - localparam `SR_MODE_RSVD` = 2'd3.
- Sub-module `sr_stage` is purely combinational. Parameter `N`; inputs `x[N-1:0]`, `amt` (K bits, a one-hot power of two or 0), `fill_sign`, `rot`; output `y[N-1:0]`.
- The top level instantiates one `sr_stage` and muxes its amount with `1 << idx`. The stage is not replicated.

## Test plan
- SR_ROT, `a` = 32'h00000001, `b` = 1 -> `r` = 32'h80000000; `out_valid` rises exactly 5 cycles after the accept edge.
- SR_LOGIC, `a` = 32'h80000000, `b` = 31 -> 32'h00000001. SR_ARITH, same operands -> 32'hFFFFFFFF. SR_ARITH, `a` = 32'h80000000, `b` = 4 -> 32'hF8000000.
- SR_ROT, `a` = 32'h12345678, `b` = 8 -> 32'h78123456; `b` = 0 -> 32'h12345678, with the same 5-cycle latency.
- Backpressure: hold `out_ready` = 0 for 10 cycles -> `out_valid` stays 1, `r` stays stable, `in_ready` stays 0. Changing `a`/`b` and pulsing `in_valid` during SHIFT has no effect on the result.
- Back-to-back: handshake in DONE with `in_valid` held 1 -> the next request is accepted at the following edge, not the same one.
- Assert `rst_n` = 0 during SHIFT stage 2 -> `out_valid` = 0 and `in_ready` = 1 immediately. After release, a new request (SR_LOGIC, 32'hF0000000, `b` = 4) -> 32'h0F000000.

Source files
------------

// File: rtl/shift_pkg.sv
// ----------------------------------------------------------------------------
// shift_pkg
// Shared types for the iterative right shifter/rotator.
//   sr_mode_t    : shift flavour selected per request
//   sr_state_t   : control FSM states of shift_right_iter
//   SR_MODE_RSVD : unused mode encoding, handled as a logical shift
// ----------------------------------------------------------------------------
package shift_pkg;

    typedef enum logic [1:0] {
        SR_LOGIC = 2'd0,
        SR_ARITH = 2'd1,
        SR_ROT   = 2'd2
    } sr_mode_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } sr_state_t;

    localparam logic [1:0] SR_MODE_RSVD = 2'd3;

endpackage

// File: rtl/sr_stage.sv
// ----------------------------------------------------------------------------
// sr_stage
// One combinational barrel stage: shifts x right by amt, where amt is either
// zero or a single power of two (at most N/2).
//   x         : data in
//   amt       : shift distance (0 or one-hot value)
//   fill_sign : bit shifted in at the top when not rotating
//   rot       : 1 = rotate (bits leaving the LSB re-enter at the MSB)
//   y         : data out
// ----------------------------------------------------------------------------
module sr_stage #(
    parameter  int N = 32,
    localparam int K = $clog2(N),
    localparam int H = N / 2
) (
    input  logic [N-1:0] x,
    input  logic [K-1:0] amt,
    input  logic         fill_sign,
    input  logic         rot,
    output logic [N-1:0] y
);

    // The largest distance is N/2, so only N/2 extension bits above x can
    // ever be pulled into the result window. For a rotate those are the low
    // bits of x itself.
    logic [H-1:0]   w_hi;
    logic [N+H-1:0] w_ext;

    assign w_hi  = rot ? x[H-1:0] : {H{fill_sign}};
    assign w_ext = {w_hi, x};

    always_comb begin
        y = x;
        for (int k = 0; k < K; k++) begin
            if (amt[k]) begin
                y = w_ext[(1 << k) +: N];
            end
        end
    end

endmodule

// File: rtl/shift_right_iter.sv
// ----------------------------------------------------------------------------
// shift_right_iter
// Multi-cycle right shifter/rotator. A request is accepted on the input
// handshake, then one shift-amount bit is resolved per cycle (stage idx
// shifts by 2^idx) using a single shared sr_stage. The result is presented
// on the output handshake until consumed.
//   clk, rst_n          : clock, asynchronous active-low reset
//   in_valid / in_ready : request handshake (ready only in IDLE)
//   a, b, mode          : operand, shift amount, shift flavour
//   r                   : result (valid while out_valid = 1)
//   out_valid/out_ready : result handshake
// ----------------------------------------------------------------------------
module shift_right_iter
    import shift_pkg::*;
#(
    parameter  int N = 32,
    localparam int K = $clog2(N)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [N-1:0]        a,
    input  logic [K-1:0]        b,
    input  shift_pkg::sr_mode_t mode,
    output logic [N-1:0]        r,
    output logic                out_valid,
    input  logic                out_ready
);

    sr_state_t r_state, w_state_next;
    logic [N-1:0] r_work, w_work_next;
    logic [K-1:0] r_idx, w_idx_next;
    logic [K-1:0] r_b, w_b_next;
    sr_mode_t     r_mode, w_mode_next;
    logic         r_sign, w_sign_next;

    logic [K-1:0] w_amt;
    logic         w_rot;
    logic         w_fill;
    logic [N-1:0] w_stage_y;

    // Stage idx contributes 2^idx only when the matching amount bit is set.
    assign w_amt  = r_b[r_idx] ? (K'(1) << r_idx) : '0;
    // Reserved mode encoding falls through to a zero-fill logical shift.
    assign w_rot  = (r_mode == SR_ROT);
    assign w_fill = (r_mode == SR_ARITH) & r_sign;

    sr_stage #(.N(N)) u_stage (
        .x         (r_work),
        .amt       (w_amt),
        .fill_sign (w_fill),
        .rot       (w_rot),
        .y         (w_stage_y)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_work  <= '0;
            r_idx   <= '0;
            r_b     <= '0;
            r_mode  <= SR_LOGIC;
            r_sign  <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_work  <= w_work_next;
            r_idx   <= w_idx_next;
            r_b     <= w_b_next;
            r_mode  <= w_mode_next;
            r_sign  <= w_sign_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_work_next  = r_work;
        w_idx_next   = r_idx;
        w_b_next     = r_b;
        w_mode_next  = r_mode;
        w_sign_next  = r_sign;
        case (r_state)
            IDLE: begin
                if (in_valid) begin
                    w_work_next  = a;
                    w_b_next     = b;
                    w_mode_next  = mode;
                    w_sign_next  = a[N-1];
                    w_idx_next   = '0;
                    w_state_next = SHIFT;
                end
            end
            SHIFT: begin
                w_work_next = w_stage_y;
                if (r_idx == K'(K - 1)) begin
                    w_idx_next   = '0;
                    w_state_next = DONE;
                end else begin
                    w_idx_next = r_idx + K'(1);
                end
            end
            DONE: begin
                if (out_ready) begin
                    w_state_next = IDLE;
                end
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    assign in_ready  = (r_state == IDLE);
    assign out_valid = (r_state == DONE);
    assign r         = r_work;

endmodule

// File: tb/tb_shift_right_iter.sv
module tb_shift_right_iter;
    import shift_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_a;
    logic [4:0]  in_b;
    sr_mode_t    in_mode;
    logic [31:0] r;
    logic        out_valid;
    logic        out_ready;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    shift_right_iter #(.N(32)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (in_a),
        .b         (in_b),
        .mode      (in_mode),
        .r         (r),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    typedef struct {
        logic [31:0] a;
        logic [4:0]  b;
        sr_mode_t    mode;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs[12];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Present a request at a negedge and return #1 after the accept edge.
    task automatic start_op(input logic [31:0] a_v, input logic [4:0] b_v, input sr_mode_t m_v);
        int guard;
        guard = 0;
        @(negedge clk);
        while (!in_ready && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 50) begin
            check("in_ready_timeout", 32'(in_ready), 32'd1);
        end
        in_a     = a_v;
        in_b     = b_v;
        in_mode  = m_v;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    // Count edges until out_valid (sampled #1 after each edge), bounded.
    task automatic wait_done(output int lat);
        lat = 0;
        while (!out_valid && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
        end
        if (!out_valid) begin
            check("out_valid_timeout", 32'(out_valid), 32'd1);
        end
    endtask

    task automatic finish_op();
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
    endtask

    initial begin
        int lat;

        vecs[0]  = '{32'h00000001, 5'd1,  SR_ROT,   32'h80000000};
        vecs[1]  = '{32'h80000000, 5'd31, SR_LOGIC, 32'h00000001};
        vecs[2]  = '{32'h80000000, 5'd31, SR_ARITH, 32'hFFFFFFFF};
        vecs[3]  = '{32'h80000000, 5'd4,  SR_ARITH, 32'hF8000000};
        vecs[4]  = '{32'h12345678, 5'd8,  SR_ROT,   32'h78123456};
        vecs[5]  = '{32'h12345678, 5'd0,  SR_ROT,   32'h12345678};
        vecs[6]  = '{32'h7FFFFFFF, 5'd3,  SR_ARITH, 32'h0FFFFFFF};
        vecs[7]  = '{32'h80000000, 5'd4,  sr_mode_t'(SR_MODE_RSVD), 32'h08000000};
        vecs[8]  = '{32'h00000001, 5'd31, SR_ROT,   32'h00000002};
        vecs[9]  = '{32'hDEADBEEF, 5'd16, SR_LOGIC, 32'h0000DEAD};
        vecs[10] = '{32'hDEADBEEF, 5'd16, SR_ROT,   32'hBEEFDEAD};
        vecs[11] = '{32'hC0000000, 5'd1,  SR_ARITH, 32'hE0000000};

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_a      = 32'h0;
        in_b      = 5'd0;
        in_mode   = SR_LOGIC;
        out_ready = 1'b0;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_r", r, 32'h0);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;

        // Table-driven vectors, each with the fixed latency check
        for (int i = 0; i < 12; i++) begin
            start_op(vecs[i].a, vecs[i].b, vecs[i].mode);
            check($sformatf("vec%0d_in_ready_busy", i), 32'(in_ready), 32'd0);
            wait_done(lat);
            check($sformatf("vec%0d_latency", i), 32'(lat), 32'd5);
            check($sformatf("vec%0d_r", i), r, vecs[i].exp);
            $display("vec %0d: a=%h b=%0d mode=%0d r=%h exp=%h lat=%0d",
                     i, vecs[i].a, vecs[i].b, vecs[i].mode, r, vecs[i].exp, lat);
            finish_op();
            check($sformatf("vec%0d_in_ready_after", i), 32'(in_ready), 32'd1);
        end

        // Input changes and in_valid pulses during SHIFT, then backpressure
        start_op(32'hF0F0F0F0, 5'd4, SR_LOGIC);
        in_a     = 32'hFFFFFFFF;
        in_b     = 5'd0;
        in_mode  = SR_ROT;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        wait_done(lat);
        check("bp_latency", 32'(lat + 1), 32'd5);
        check("bp_r", r, 32'h0F0F0F0F);
        for (int c = 0; c < 10; c++) begin
            @(posedge clk);
            #1;
            check($sformatf("bp%0d_out_valid", c), 32'(out_valid), 32'd1);
            check($sformatf("bp%0d_in_ready", c), 32'(in_ready), 32'd0);
            check($sformatf("bp%0d_r", c), r, 32'h0F0F0F0F);
        end
        $display("backpressure: r=%h held 10 cycles", r);
        finish_op();
        check("bp_in_ready_after", 32'(in_ready), 32'd1);

        // Back-to-back: in_valid held high across the output handshake
        start_op(32'hFFFF0000, 5'd8, SR_LOGIC);
        wait_done(lat);
        check("b2b_first_r", r, 32'h00FFFF00);
        in_a      = 32'h0000ABCD;
        in_b      = 5'd4;
        in_mode   = SR_LOGIC;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check("b2b_in_ready_after_td", 32'(in_ready), 32'd1);
        check("b2b_out_valid_after_td", 32'(out_valid), 32'd0);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        check("b2b_accepted_td1", 32'(in_ready), 32'd0);
        wait_done(lat);
        check("b2b_latency", 32'(lat), 32'd5);
        check("b2b_second_r", r, 32'h00000ABC);
        $display("back-to-back: second r=%h lat=%0d", r, lat);
        finish_op();

        // Reset asserted mid-SHIFT
        start_op(32'hAAAAAAAA, 5'd31, SR_ARITH);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("midrst_out_valid", 32'(out_valid), 32'd0);
        check("midrst_in_ready", 32'(in_ready), 32'd1);
        check("midrst_r", r, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        start_op(32'hF0000000, 5'd4, SR_LOGIC);
        wait_done(lat);
        check("postrst_latency", 32'(lat), 32'd5);
        check("postrst_r", r, 32'h0F000000);
        $display("post-reset: r=%h lat=%0d", r, lat);
        finish_op();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
